pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and run-control unit for the 5-stage pipeline. It drives the en/stall/flush inputs of the four segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
- Decisions use hazard indications from the stages and memory handshakes.
- A small FSM tracks data-memory waits, a wait timeout, and debug halt/resume.
- Stall/flush outputs are combinational from the registered state and the current-cycle inputs, so the segment registers sample them on the same edge.

Parameters:
MAX_WAIT, 255, maximum consecutive dmem wait cycles before a bus error; legal range 1..2^WAIT_W-1.
WAIT_W, 8, width of the wait counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
load_use  in  1  EX holds a load whose rd matches an ID-stage rs (rd != 0)
br_taken_ex  in  1  EX-stage branch/jump resolved taken; PC loads target this edge
imem_ready  in  1  instruction fetch data valid this cycle
dmem_req_mem  in  1  MEM stage has a load/store in flight
dmem_ready  in  1  data memory completes the MEM-stage access this cycle
halt_req  in  1  debug halt request (level)
resume  in  1  debug resume pulse
seg_en  out  1  common en to all segment registers
pc_stall  out  1  hold PC
if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  segment stall
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  segment flush (bubble insert)
halted  out  1  FSM in HALT
bus_err  out  1  sticky dmem timeout flag

Behaviour:
- States:
  - RUN=0, DMEM_WAIT=1, HALT=2 (2-bit encoding).
  - Reset state is RUN, wait_cnt=0, bus_err=0.
- Outputs while rst=1: all four flushes=1, all stalls=0, pc_stall=1, seg_en=1, halted=0.
- Default in RUN/DMEM_WAIT with no hazard: seg_en=1, all stalls/flushes=0, pc_stall=0.
- Hazard priority, highest first; only the first matching row applies:
  1. dmem_req_mem && !dmem_ready: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall=1; mem_wb_flush=1. br_taken_ex and load_use are ignored this cycle; they are re-evaluated next cycle because their stages are frozen.
  2. br_taken_ex: if_id_flush=1, id_ex_flush=1; pc_stall=0.
  3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble per load_use assertion cycle.
  4. !imem_ready: pc_stall=1, if_id_flush=1; downstream stages advance.
- Segment flush has priority over stall inside the segment register. This unit never asserts both on the same segment.
- RUN -> DMEM_WAIT:
  - Condition: row 1 is active.
  - wait_cnt loads 1.
- DMEM_WAIT:
  - Row 1 outputs are held while !dmem_ready; wait_cnt increments each cycle.
  - On dmem_ready: row 1 releases that cycle (normal rows 2-4 apply), wait_cnt clears, and the next state is HALT if halt_req else RUN.
  - If wait_cnt reaches MAX_WAIT while !dmem_ready: bus_err<=1, next state HALT, wait_cnt clears.
- RUN -> HALT:
  - Condition: halt_req=1 and row 1 is not active.
  - The current cycle still behaves as RUN, so the pipeline advances one last time.
- HALT:
  - seg_en=0, pc_stall=1, all stalls/flushes=0, halted=1.
  - resume=1 -> RUN next cycle, but only when halt_req=0; resume is ignored while halt_req=1.
  - bus_err does not block resume.
- bus_err clears only on rst.
- rst in any state, including mid-DMEM_WAIT: state RUN, counters cleared next edge, and the rst output values above apply during the reset cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds 32-bit outputs stall_cycles, flush_events, dmem_wait_cycles, all reset to 0 and wrapping at 2^32.
  - stall_cycles increments each cycle pc_stall=1 in RUN/DMEM_WAIT.
  - flush_events increments once per cycle any flush=1 (not in rst).
  - dmem_wait_cycles increments each cycle row 1 is active.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> all flushes=1, pc_stall=1, seg_en=1. After release with no hazards -> all stalls/flushes=0, halted=0, bus_err=0.
- Load-use: load_use=1 for 1 cycle -> that cycle pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0. Next cycle all 0.
- Branch vs load_use: br_taken_ex=1 and load_use=1 together -> if_id_flush=id_ex_flush=1, pc_stall=0, if_id_stall=0.
- Dmem wait: dmem_req_mem=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles of pc/if_id/id_ex/ex_mem stall=1 with mem_wb_flush=1. 4th cycle all 0, state RUN.
- Timeout with MAX_WAIT=4: dmem_ready held 0 -> bus_err=1 and halted=1 after the 4th wait cycle. resume pulse (halt_req=0) -> RUN; bus_err stays 1 until rst.
- Halt during wait: halt_req=1 raised mid-DMEM_WAIT -> no HALT until dmem_ready. Then HALT with seg_en=0. resume while halt_req=1 is ignored; after halt_req=0, resume returns to RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and run-control unit driving segment register en/stall/flush and PC hold
// Ports: clk, rst (sync, active-high); hazard inputs load_use, br_taken_ex, imem_ready,
// dmem_req_mem, dmem_ready; debug halt_req/resume; outputs seg_en, pc_stall, per-segment
// stall/flush, halted, sticky bus_err. Define PIPE_PERF_CNT_EN to add the 32-bit counters
// stall_cycles, flush_events, dmem_wait_cycles.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        br_taken_ex,
  input  logic        imem_ready,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        seg_en,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        halted,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] dmem_wait_cycles,
`endif
  output logic        bus_err
);
  typedef enum logic [1:0] {RUN = 2'd0, DMEM_WAIT = 2'd1, HALT = 2'd2} state_t;
  state_t state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, cnt_nx, cnt_inc;
  logic row1, timeout;
  // Once in DMEM_WAIT the stall is held until dmem_ready, independent of dmem_req_mem.
  assign row1 = state != HALT && (state == DMEM_WAIT || dmem_req_mem) && !dmem_ready;
  // Entering the wait counts as wait cycle 1; the count reaching MAX_WAIT is the timeout.
  assign cnt_inc = state == DMEM_WAIT ? wait_cnt + 1'b1 : WAIT_W'(1);
  assign timeout = row1 && cnt_inc == WAIT_W'(MAX_WAIT);
  always_comb begin
    state_nx = halt_req ? HALT : RUN;
    cnt_nx   = '0;
    if (state == HALT) state_nx = (resume && !halt_req) ? RUN : HALT;
    else if (row1) begin
      state_nx = timeout ? HALT : DMEM_WAIT;
      cnt_nx   = timeout ? '0 : cnt_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
      bus_err  <= bus_err | timeout;
    end
  end
  always_comb begin
    seg_en       = 1'b1;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      pc_stall     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state == HALT) begin
      seg_en   = 1'b0;
      pc_stall = 1'b1;
      halted   = 1'b1;
    end else if (row1) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (br_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles     <= '0;
      flush_events     <= '0;
      dmem_wait_cycles <= '0;
    end else begin
      stall_cycles     <= stall_cycles + 32'(pc_stall && state != HALT);
      flush_events     <= flush_events + 32'(if_id_flush | id_ex_flush | ex_mem_flush | mem_wb_flush);
      dmem_wait_cycles <= dmem_wait_cycles + 32'(row1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with MAX_WAIT=4
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, load_use, br_taken_ex, imem_ready, dmem_req_mem, dmem_ready, halt_req, resume;
  logic seg_en, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, bus_err;
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  // {seg_en, pc_stall, stalls if/id..mem/wb, flushes if/id..mem/wb, halted, bus_err}
  localparam logic [11:0] RST  = 12'b1_1_0000_1111_0_0;
  localparam logic [11:0] NORM = 12'b1_0_0000_0000_0_0;
  localparam logic [11:0] LU   = 12'b1_1_1000_0100_0_0;
  localparam logic [11:0] BR   = 12'b1_0_0000_1100_0_0;
  localparam logic [11:0] IM   = 12'b1_1_0000_1000_0_0;
  localparam logic [11:0] DW   = 12'b1_1_1110_0001_0_0;
  localparam logic [11:0] HLT  = 12'b0_1_0000_0000_1_0;
  localparam logic [11:0] BE   = 12'b0_0_0000_0000_0_1;

  pipe_hazard_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .br_taken_ex(br_taken_ex),
    .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume(resume), .seg_en(seg_en), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .mem_wb_stall(mem_wb_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge, queue its expectation, check the combinational outputs mid-cycle.
  task automatic step(input logic [7:0] in, input logic [11:0] exp, input string tag);
    logic [11:0] obs, want;
    @(negedge clk);
    {rst, load_use, br_taken_ex, imem_ready, dmem_req_mem, dmem_ready, halt_req, resume} = in;
    exp_q.push_back(exp);
    #1;
    obs = {seg_en, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, bus_err};
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // input order: rst, load_use, br_taken_ex, imem_ready, dmem_req_mem, dmem_ready, halt_req, resume
  initial begin
    step(8'b1001_0000, RST, "reset0");
    step(8'b1001_0000, RST, "reset1");
    step(8'b0001_0000, NORM, "idle_after_reset");
    step(8'b0101_0000, LU, "load_use");
    step(8'b0001_0000, NORM, "after_load_use");
    step(8'b0111_0000, BR, "branch_over_load_use");
    step(8'b0000_0000, IM, "imem_not_ready");
    step(8'b0001_1000, DW, "dmem_wait1");
    step(8'b0001_1000, DW, "dmem_wait2");
    step(8'b0001_1000, DW, "dmem_wait3");
    step(8'b0001_1100, NORM, "dmem_done");
    step(8'b0001_0000, NORM, "back_in_run");
    step(8'b0111_1000, DW, "dmem_over_branch");
    step(8'b0011_1100, BR, "branch_on_release");
    step(8'b0001_1000, DW, "hw_wait1");
    step(8'b0001_1010, DW, "hw_wait_halt_req");
    step(8'b0001_1110, NORM, "hw_release");
    step(8'b0001_0011, HLT, "halt_resume_ignored");
    step(8'b0001_0010, HLT, "halt_held");
    step(8'b0001_0001, HLT, "halt_resume");
    step(8'b0001_0000, NORM, "run_after_resume");
    step(8'b0001_0010, NORM, "halt_req_last_advance");
    step(8'b0001_0000, HLT, "halt_from_run");
    step(8'b0001_0001, HLT, "halt_resume2");
    step(8'b0001_0000, NORM, "run_after_resume2");
    step(8'b0001_1000, DW, "to_wait1");
    step(8'b0001_1000, DW, "to_wait2");
    step(8'b0001_1000, DW, "to_wait3");
    step(8'b0001_1000, DW, "to_wait4");
    step(8'b0001_1000, HLT | BE, "timeout_halt");
    step(8'b0001_0001, HLT | BE, "timeout_resume");
    step(8'b0001_0000, NORM | BE, "bus_err_sticky");
    step(8'b1001_0000, RST | BE, "reset_with_bus_err");
    step(8'b0001_0000, NORM, "bus_err_cleared");
    step(8'b0001_1000, DW, "wait_before_reset");
    step(8'b1001_1000, RST, "reset_mid_wait");
    step(8'b0001_0000, NORM, "run_after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
